game_control: RTL and testbench

Match sequencer for pong: owns the left/right score counters that feed the score display, runs the attract / serve / play / game-over state machine, and issues serve requests to the ball logic. It sits upstream of the score display and alongside the ball motion block. Miss events come in from the ball logic and score nibbles go out, driving the 4-bit counter inputs of the score display directly.

---
 rtl/game_control.sv | 170 +++++++++++++++++
 tb/tb_game_control.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_control.sv
// game_control: pong match sequencer.
// Owns the left/right score counters, runs the ATTRACT / SERVE_WAIT / PLAY /
// GAME_OVER state machine and issues one-cycle serve pulses to the ball logic.
// All inputs are levels synchronous to clk; each acts only on its rising edge.
//
// Optional feature macro: GAMEOVER_TIMEOUT_EN
//   defined   -> GAME_OVER returns to ATTRACT after GAMEOVER_FRAMES frame ticks
//   undefined -> GAME_OVER persists until a coin edge or reset
//
// Event contract: there is no valid/ready handshake here. serve is a
// single-cycle strobe; serve_dir is valid whenever serve is high and the
// ball logic must accept the strobe unconditionally.
`timescale 1ns/1ps

module game_control #(
  parameter int WIN_SCORE       = 11,
  parameter int SERVE_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       coin,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       serve,
  output logic       serve_dir,
  output logic       ball_enable,
  output logic       attract,
  output logic       game_over,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ATTRACT    = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] WIN_4      = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
`ifdef GAMEOVER_TIMEOUT_EN
  localparam logic [7:0] GO_LOAD    = 8'(GAMEOVER_FRAMES);
`endif

  state_t     state, state_n;
  logic [7:0] timer, timer_n;
  logic [3:0] left_n, right_n;
  logic       serve_n, dir_n;
  logic       vsync_q, coin_q, miss_left_q, miss_right_q;
  logic       tick, coin_e, miss_left_e, miss_right_e;
  logic       start, point, won;

  // Rising-edge events: current level high, previous sample low.
  assign tick         = vsync & ~vsync_q;
  assign coin_e       = coin & ~coin_q;
  assign miss_left_e  = miss_left & ~miss_left_q;
  assign miss_right_e = miss_right & ~miss_right_q;

  // State, timer, scores, serve strobe and edge-detect history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ATTRACT;
      timer        <= 8'd0;
      left_score   <= 4'd0;
      right_score  <= 4'd0;
      serve        <= 1'b0;
      serve_dir    <= 1'b0;
      vsync_q      <= 1'b0;
      coin_q       <= 1'b0;
      miss_left_q  <= 1'b0;
      miss_right_q <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      left_score   <= left_n;
      right_score  <= right_n;
      serve        <= serve_n;
      serve_dir    <= dir_n;
      vsync_q      <= vsync;
      coin_q       <= coin;
      miss_left_q  <= miss_left;
      miss_right_q <= miss_right;
    end
  end

  // Next-state logic: per-state actions, then shared point / new-game actions.
  always_comb begin
    state_n = state;
    timer_n = timer;
    left_n  = left_score;
    right_n = right_score;
    dir_n   = serve_dir;
    serve_n = 1'b0;
    start   = 1'b0;
    point   = 1'b0;
    won     = 1'b0;
    unique case (state)
      ATTRACT: begin
        start = coin_e;
      end
      SERVE_WAIT: begin
        if (tick) begin
          timer_n = timer - 8'd1;
          if (timer == 8'd1) begin
            serve_n = 1'b1;
            state_n = PLAY;
          end
        end
      end
      PLAY: begin
        // miss_left has priority; a simultaneous miss_right is dropped.
        if (miss_left_e) begin
          right_n = right_score + 4'd1;
          dir_n   = 1'b0;
          point   = 1'b1;
          won     = (right_n == WIN_4);
        end else if (miss_right_e) begin
          left_n  = left_score + 4'd1;
          dir_n   = 1'b1;
          point   = 1'b1;
          won     = (left_n == WIN_4);
        end
      end
      GAME_OVER: begin
        start = coin_e;
`ifdef GAMEOVER_TIMEOUT_EN
        if (!coin_e && tick) begin
          timer_n = timer - 8'd1;
          if (timer == 8'd1) state_n = ATTRACT;
        end
`endif
      end
      default: state_n = ATTRACT;
    endcase

    if (point) begin
      if (won) begin
        state_n = GAME_OVER;
`ifdef GAMEOVER_TIMEOUT_EN
        timer_n = GO_LOAD;
`endif
      end else begin
        state_n = SERVE_WAIT;
        timer_n = SERVE_LOAD;
      end
    end

    // A coin edge wins over a coincident frame tick: the fresh load is kept.
    if (start) begin
      left_n  = 4'd0;
      right_n = 4'd0;
      dir_n   = 1'b0;
      timer_n = SERVE_LOAD;
      state_n = SERVE_WAIT;
    end
  end

  // Decoded status outputs and state visibility.
  always_comb begin
    attract     = (state == ATTRACT);
    game_over   = (state == GAME_OVER);
    ball_enable = (state == ATTRACT) || (state == PLAY);
    state_dbg   = state;
  end

endmodule

// File: tb/tb_game_control.sv
// tb_game_control: directed table of match operations plus randomized input
// traffic, all checked against a frame-counting reference model of the match.
`timescale 1ns/1ps

module tb_game_control;

  localparam int WIN = 11;
  localparam int SF  = 60;
  localparam int GF  = 180;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vsync = 1'b0, coin = 1'b0, miss_left = 1'b0, miss_right = 1'b0;
  logic [3:0] left_score, right_score;
  logic serve, serve_dir, ball_enable, attract, game_over;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  game_control #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .GAMEOVER_FRAMES(GF)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .coin(coin),
    .miss_left(miss_left), .miss_right(miss_right),
    .left_score(left_score), .right_score(right_score),
    .serve(serve), .serve_dir(serve_dir), .ball_enable(ball_enable),
    .attract(attract), .game_over(game_over), .state_dbg(state_dbg)
  );

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];
  bit lockstep_on = 1'b0;
  int tick_edges = 0;
  int ev_ticks = 0;
  int gen_cnt = 0;
  logic tb_vs_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame ticks: vsync high for one cycle every 4..7 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (gen_cnt == 0) begin
        vsync = 1'b1;
        gen_cnt = $urandom_range(3, 6);
      end else begin
        vsync = 1'b0;
        gen_cnt--;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef enum int {PH_IDLE, PH_WAIT, PH_RALLY, PH_DONE} phase_t;
  phase_t m_phase = PH_IDLE;
  int m_l = 0, m_r = 0, m_ticks = 0;
  bit m_dir = 1'b0, m_serve = 1'b0;
  bit p_vs = 1'b0, p_coin = 1'b0, p_ml = 1'b0, p_mr = 1'b0;

  task automatic m_start();
    m_l = 0; m_r = 0; m_dir = 1'b0; m_ticks = 0; m_phase = PH_WAIT;
  endtask

  task automatic m_point(input int s);
    m_ticks = 0;
    m_phase = (s == WIN) ? PH_DONE : PH_WAIT;
  endtask

  // Model advances on each clock edge; counts ticks since the last load upward.
  always @(posedge clk) begin : model_blk
    bit te, ce, le, re;
    if (vsync && !tb_vs_prev) tick_edges++;
    tb_vs_prev = vsync;
    te = vsync && !p_vs;
    ce = coin && !p_coin;
    le = miss_left && !p_ml;
    re = miss_right && !p_mr;
    m_serve = 1'b0;
    if (reset) begin
      m_phase = PH_IDLE; m_l = 0; m_r = 0; m_dir = 1'b0; m_ticks = 0;
      p_vs = 1'b0; p_coin = 1'b0; p_ml = 1'b0; p_mr = 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE: if (ce) m_start();
        PH_WAIT: if (te) begin
          m_ticks++;
          if (m_ticks == SF) begin
            m_serve = 1'b1;
            m_phase = PH_RALLY;
            exp_q.push_back(m_dir);
          end
        end
        PH_RALLY: if (le) begin
          m_r++; m_dir = 1'b0; m_point(m_r);
        end else if (re) begin
          m_l++; m_dir = 1'b1; m_point(m_l);
        end
        PH_DONE: if (ce) m_start();
`ifdef GAMEOVER_TIMEOUT_EN
          else if (te) begin
            m_ticks++;
            if (m_ticks == GF) m_phase = PH_IDLE;
          end
`endif
        default: m_phase = PH_IDLE;
      endcase
      p_vs = vsync; p_coin = coin; p_ml = miss_left; p_mr = miss_right;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (lockstep_on) begin
      check("lockstep",
            int'({left_score, right_score, serve, serve_dir, ball_enable, attract, game_over}),
            int'({4'(m_l), 4'(m_r), m_serve, m_dir,
                  (m_phase == PH_IDLE) || (m_phase == PH_RALLY),
                  m_phase == PH_IDLE, m_phase == PH_DONE}));
      if (serve) begin
        if (exp_q.size() == 0) check("serve_unexpected", 1, 0);
        else check("serve_dir_q", int'(serve_dir), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_step();
    @(negedge clk);
    #1;
  endtask

  // Raise the given inputs for 'hold' cycles, then drop them.
  task automatic pulse(input bit c, input bit ml, input bit mr, input int hold);
    drive_step();
    coin = c; miss_left = ml; miss_right = mr;
    @(posedge clk);
    #1;
    ev_ticks = tick_edges;
    repeat (hold - 1) @(posedge clk);
    drive_step();
    coin = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_serve(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!serve && n < 4000);
    check({name, "_seen"}, int'(serve), 1);
  endtask

  task automatic wait_ticks_to(input int target);
    int n = 0;
    while (tick_edges < target && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tick_wait", int'(tick_edges >= target), 1);
  endtask

  task automatic check_status(input string name, input int l, input int r, input logic [2:0] flags);
    check({name, "_left"}, int'(left_score), l);
    check({name, "_right"}, int'(right_score), r);
    check({name, "_flags"}, int'({attract, ball_enable, game_over}), int'(flags));
  endtask

  // ---------------- directed table ----------------
  localparam int OP_FRAMES = 0, OP_COIN = 1, OP_ML = 2, OP_MR = 3, OP_BOTH = 4, OP_SERVE = 5;

  typedef struct {
    string      name;
    int         op;
    int         hold;
    bit         loads;
    int         exp_l;
    int         exp_r;
    logic [2:0] exp_flags;  // {attract, ball_enable, game_over}
    logic       exp_dir;
  } vec_t;

  vec_t vecs[14];
  int   load_ticks = 0;

  initial begin
    // flags: 110 attract, 000 serve wait, 010 play, 001 game over
    vecs[0]  = '{"idle_frames",   OP_FRAMES, 5,  1'b0, 0, 0, 3'b110, 1'b0};
    vecs[1]  = '{"attract_miss",  OP_MR,     1,  1'b0, 0, 0, 3'b110, 1'b0};
    vecs[2]  = '{"coin_start",    OP_COIN,   1,  1'b1, 0, 0, 3'b000, 1'b0};
    vecs[3]  = '{"first_serve",   OP_SERVE,  0,  1'b0, 0, 0, 3'b010, 1'b0};
    vecs[4]  = '{"mr_held",       OP_MR,     10, 1'b1, 1, 0, 3'b000, 1'b0};
    vecs[5]  = '{"serve_after_mr",OP_SERVE,  0,  1'b0, 1, 0, 3'b010, 1'b1};
    vecs[6]  = '{"both_miss",     OP_BOTH,   1,  1'b1, 1, 1, 3'b000, 1'b0};
    vecs[7]  = '{"serve_after_bo",OP_SERVE,  0,  1'b0, 1, 1, 3'b010, 1'b0};
    vecs[8]  = '{"ml_point",      OP_ML,     1,  1'b1, 1, 2, 3'b000, 1'b0};
    vecs[9]  = '{"serve_after_ml",OP_SERVE,  0,  1'b0, 1, 2, 3'b010, 1'b0};
    vecs[10] = '{"play_coin",     OP_COIN,   1,  1'b0, 1, 2, 3'b010, 1'b0};
    vecs[11] = '{"ml_point2",     OP_ML,     1,  1'b1, 1, 3, 3'b000, 1'b0};
    vecs[12] = '{"wait_miss",     OP_MR,     1,  1'b0, 1, 3, 3'b000, 1'b0};
    vecs[13] = '{"serve_again",   OP_SERVE,  0,  1'b0, 1, 3, 3'b010, 1'b0};

    // reset
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lockstep_on = 1'b1;
    check_status("reset", 0, 0, 3'b110);
    check("reset_serve", int'(serve), 0);
    check("reset_dir", int'(serve_dir), 0);
    drive_step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_FRAMES: begin
          int sc = 0;
          int target = tick_edges + vecs[i].hold;
          int n = 0;
          while (tick_edges < target && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (serve) sc++;
          end
          check({vecs[i].name, "_serves"}, sc, 0);
        end
        OP_COIN: pulse(1'b1, 1'b0, 1'b0, vecs[i].hold);
        OP_ML:   pulse(1'b0, 1'b1, 1'b0, vecs[i].hold);
        OP_MR:   pulse(1'b0, 1'b0, 1'b1, vecs[i].hold);
        OP_BOTH: pulse(1'b0, 1'b1, 1'b1, vecs[i].hold);
        OP_SERVE: begin
          wait_serve(vecs[i].name);
          check({vecs[i].name, "_dir"}, int'(serve_dir), int'(vecs[i].exp_dir));
          check({vecs[i].name, "_latency"}, tick_edges - load_ticks, SF);
          @(posedge clk);
          #1;
          check({vecs[i].name, "_one_cycle"}, int'(serve), 0);
        end
        default: ;
      endcase
      if (vecs[i].loads) load_ticks = ev_ticks;
      check_status(vecs[i].name, vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_flags);
    end

    // Drive the right player to the winning score.
    for (int i = 0; i < WIN - 3; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1);
      if (i < WIN - 4) wait_serve("go_rally");
    end
    load_ticks = ev_ticks;
    check_status("game_over", 1, WIN, 3'b001);
    pulse(1'b0, 1'b0, 1'b1, 1);
    check_status("go_frozen", 1, WIN, 3'b001);

`ifdef GAMEOVER_TIMEOUT_EN
    wait_ticks_to(load_ticks + GF - 1);
    check_status("go_before_timeout", 1, WIN, 3'b001);
    wait_ticks_to(load_ticks + GF);
    check_status("go_timeout", 1, WIN, 3'b110);
`else
    wait_ticks_to(load_ticks + 500);
    check_status("go_persist", 1, WIN, 3'b001);
`endif

    pulse(1'b1, 1'b0, 1'b0, 1);
    load_ticks = ev_ticks;
    check_status("new_game", 0, 0, 3'b000);
    wait_serve("new_game_serve");
    check("new_game_latency", tick_edges - load_ticks, SF);

    // Build a 3/7 score, ending in SERVE_WAIT, then reset.
    for (int i = 0; i < 10; i++) begin
      if (i < 3) pulse(1'b0, 1'b0, 1'b1, 1);
      else pulse(1'b0, 1'b1, 1'b0, 1);
      if (i < 9) wait_serve("build_rally");
    end
    check_status("pre_reset", 3, 7, 3'b000);
    drive_step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_status("mid_reset", 0, 0, 3'b110);
    check("mid_reset_serve", int'(serve), 0);
    drive_step();
    reset = 1'b0;
    begin
      int sc = 0;
      int target = tick_edges + SF + 10;
      int n = 0;
      while (tick_edges < target && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
        if (serve) sc++;
      end
      check("post_reset_no_serve", sc, 0);
      check_status("post_reset", 0, 0, 3'b110);
    end

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 6000; c++) begin
      drive_step();
      coin       = ($urandom_range(0, 99) < 2);
      miss_left  = ($urandom_range(0, 99) < 10);
      miss_right = ($urandom_range(0, 99) < 10);
      reset      = ($urandom_range(0, 1999) == 0);
    end
    drive_step();
    coin = 1'b0; miss_left = 1'b0; miss_right = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("serve_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
